traffic_preempt_scheduler: RTL
==============================

Name: traffic_preempt_scheduler

Overview:
Scheduler sitting above the intersection phase controller. It arbitrates emergency-vehicle requests (T1/left approach, T2/right approach) and latched pedestrian-button requests. It freezes normal phase sequencing via hold, waits for a controller-confirmed safe state, then grants exclusive emergency green or a pedestrian walk interval. All timing runs on a 1-cycle tick strobe (1 Hz in system).

Parameters:
EMG_HOLD, 10, minimum preempt green dwell in ticks (1..255)
EMG_MAX, 30, maximum preempt green dwell in ticks incl. extension (EMG_HOLD..255)
CLEAR_MAX, 8, ticks to wait for ctrl_safe before forcing and flagging fault (1..255)
RECOVER_TIME, 3, all-red ticks after preempt (1..255)
WALK_TIME, 15, walk grant dwell in ticks (1..255)
BUZZER_TIME, 5, buzzer active while walk ticks remaining <= this (0..WALK_TIME)

Ports:
clk  in  1  clock
rst  in  1  reset
tick  in  1  time-base strobe, one clk wide
emg_req  in  2  level emergency request; [0]=T1 approach, [1]=T2 approach
ped_btn  in  2  pedestrian button pulses; [0]=T1 crossing, [1]=T2 crossing
ctrl_safe  in  1  controller reports all approaches red / clearance complete
hold  out  1  freeze normal controller sequencing
preempt_green  out  2  one-hot emergency green for the granted approach
walk_grant  out  2  one-hot walk for the granted crossing
buzzer  out  1  walk-ending audible warning
ped_pending  out  2  latched, unserved pedestrian requests
clear_fault  out  1  sticky: a CLEAR timed out
state_dbg  out  3  current state encoding

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs 0. ped_pending=0. Timers 0. rr_emg=1 and rr_ped=1, so index 0 wins the first tie. Reset mid-operation aborts immediately; no grant survives it.
- Outputs are registered and decoded from state and registers. They change one clk after the edge that samples the causing input.
- States (state_dbg): IDLE=0, CLEAR=1, PREEMPT=2, RECOVER=3, WALK=4.
- hold=1 in CLEAR, PREEMPT, RECOVER and WALK. hold=0 only in IDLE.
- Dwell timer:
  - Loaded with the parameter on state entry.
  - On each tick: if timer==1 the state's expiry condition fires; otherwise timer decrements.
  - Dwell is therefore exactly PARAM ticks. Ticks are counted only while in the state.
- Emergency arbitration: round-robin over emg_req. If both bits are set, grant index != rr_emg. rr_emg updates to the served index on entry to PREEMPT. Choice is latched as emg_dir on entry to CLEAR.
- Pedestrian latch:
  - ped_pending[i] sets on ped_btn[i]=1.
  - Clears on the cycle WALK for i is entered.
  - A press during WALK for the same i is ignored. A press for the other i latches.
- Pedestrian arbitration: round-robin by rr_ped, same rule as emergency.
- IDLE:
  - emg_req!=0 -> CLEAR. Priority over ped.
  - Else ped_pending!=0 && ctrl_safe -> WALK.
- CLEAR:
  - ctrl_safe=1 -> PREEMPT. Load EMG_HOLD; total counter = 0.
  - CLEAR_MAX ticks elapse without ctrl_safe -> PREEMPT anyway and set clear_fault. clear_fault clears only on rst.
- PREEMPT:
  - preempt_green[emg_dir]=1. The total counter increments per tick.
  - At dwell expiry, exit to RECOVER if emg_req[emg_dir]=0. If it is still 1, stay (timer held at 1).
  - Forced exit to RECOVER when total reaches EMG_MAX regardless of request.
  - A request from the other approach is not honoured until RECOVER completes.
- RECOVER: all grants 0, hold=1. At expiry:
  - emg_req!=0 -> CLEAR (round-robin; the previous direction loses a tie).
  - Else ped_pending!=0 -> WALK (ctrl_safe not required; intersection is all-red).
  - Else IDLE.
- WALK:
  - walk_grant[ped_dir]=1.
  - buzzer=1 while remaining timer <= BUZZER_TIME.
  - emg_req!=0 aborts: -> CLEAR next cycle; walk_grant and buzzer drop with the state change. The aborted crossing is not re-latched.
  - At expiry -> IDLE, or -> WALK for the other crossing if it is pending and no emg_req (ctrl_safe not required).
- tick and input change on the same cycle: the input transition is evaluated first; the new state's timer is loaded and this tick is not counted.
- preempt_green and walk_grant are never simultaneously non-zero. Each is at most one-hot.

Decomposition:
- Shared package traffic_pkg holds:
  - state enum (IDLE..WALK, 3 bits)
  - direction indices DIR_T1=0, DIR_T2=1
  - default timing constants, shared with the phase controller
- One sub-module: rr_arbiter2. It is a 2-requester round-robin picker with combinational req/last inputs and grant index plus valid output. It is instantiated twice (emergency and pedestrian).

Test Plan:
- Reset, then emg_req=01 with ctrl_safe=1 -> hold=1 next clk, state CLEAR then PREEMPT, preempt_green=01. emg_req dropped at tick 4 -> exit after exactly 10 ticks, RECOVER 3 ticks, IDLE, hold=0.
- emg_req=11 from IDLE after reset -> T1 served first (preempt_green=01). With T2 still requesting, after RECOVER -> CLEAR -> preempt_green=10.
- emg_req[0] held high continuously -> PREEMPT lasts exactly 30 ticks (EMG_MAX). Then RECOVER, then T1 re-served only if T2 is idle.
- ctrl_safe held 0 with emg_req=10 -> after 8 ticks in CLEAR, PREEMPT entered, clear_fault=1, stays 1 until rst.
- ped_btn[1] pulse, ctrl_safe=1 -> ped_pending=10, then walk_grant=10 for 15 ticks. buzzer=1 for the final 5 ticks. ped_pending clears on WALK entry.
- During WALK at tick 6, emg_req=01 -> next clk walk_grant=0, buzzer=0, state CLEAR. A ped_btn[0] press during the walk remains pending and is served after RECOVER.

Source files
------------

// File: rtl/traffic_preempt_scheduler_pkg.sv
// traffic_pkg: shared types and default timing for the intersection
// scheduler and the phase controller it sits above.
//   state_e      : scheduler state encoding, exported on state_dbg
//   DIR_T1/DIR_T2: approach / crossing indices
//   *_DEF        : default dwell lengths in ticks
package traffic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_PREEMPT = 3'd2,
      ST_RECOVER = 3'd3,
      ST_WALK    = 3'd4
   } state_e;

   localparam logic DIR_T1 = 1'b0;
   localparam logic DIR_T2 = 1'b1;

   localparam int unsigned EMG_HOLD_DEF     = 10;
   localparam int unsigned EMG_MAX_DEF      = 30;
   localparam int unsigned CLEAR_MAX_DEF    = 8;
   localparam int unsigned RECOVER_TIME_DEF = 3;
   localparam int unsigned WALK_TIME_DEF    = 15;
   localparam int unsigned BUZZER_TIME_DEF  = 5;

   function automatic logic [1:0] dir_onehot(input logic dir);
      return dir ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/traffic_preempt_scheduler_if.sv
// Handshake/status bundle between the scheduler and its environment.
//   master: drives tick, emg_req, ped_btn, ctrl_safe; observes the rest
//   slave : the scheduler itself
interface traffic_preempt_scheduler_if;
   logic       tick;
   logic [1:0] emg_req;
   logic [1:0] ped_btn;
   logic       ctrl_safe;
   logic       hold;
   logic [1:0] preempt_green;
   logic [1:0] walk_grant;
   logic       buzzer;
   logic [1:0] ped_pending;
   logic       clear_fault;
   logic [2:0] state_dbg;

   modport master (
      output tick, emg_req, ped_btn, ctrl_safe,
      input  hold, preempt_green, walk_grant, buzzer, ped_pending,
             clear_fault, state_dbg
   );

   modport slave (
      input  tick, emg_req, ped_btn, ctrl_safe,
      output hold, preempt_green, walk_grant, buzzer, ped_pending,
             clear_fault, state_dbg
   );
endinterface

// File: rtl/traffic_preempt_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin picker, purely combinational.
//   req_i     : request vector
//   last_i    : index served most recently (loses a tie)
//   gnt_idx_o : chosen index (meaningful only when gnt_vld_o)
//   gnt_vld_o : at least one request present
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       gnt_idx_o,
   output logic       gnt_vld_o
);
   always_comb begin
      gnt_vld_o = |req_i;
      if (&req_i) gnt_idx_o = ~last_i;
      else        gnt_idx_o = req_i[1];
   end
endmodule

// File: rtl/traffic_preempt_scheduler.sv
// traffic_preempt_scheduler: arbitrates emergency preemption and
// pedestrian walk requests above the phase controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of traffic_preempt_scheduler_if (tick strobe,
//              requests, ctrl_safe in; hold, grants, buzzer, pending,
//              clear_fault, state_dbg out)
// All outputs are registered from next-state values, so they move
// together with state_dbg.
module traffic_preempt_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned EMG_HOLD     = EMG_HOLD_DEF,
   parameter int unsigned EMG_MAX      = EMG_MAX_DEF,
   parameter int unsigned CLEAR_MAX    = CLEAR_MAX_DEF,
   parameter int unsigned RECOVER_TIME = RECOVER_TIME_DEF,
   parameter int unsigned WALK_TIME    = WALK_TIME_DEF,
   parameter int unsigned BUZZER_TIME  = BUZZER_TIME_DEF
) (
   input logic                       clk,
   input logic                       rst,
   traffic_preempt_scheduler_if.slave bus
);
   localparam logic [7:0] EMG_HOLD_C  = 8'(EMG_HOLD);
   localparam logic [7:0] EMG_MAX_C   = 8'(EMG_MAX);
   localparam logic [7:0] CLEAR_C     = 8'(CLEAR_MAX);
   localparam logic [7:0] RECOVER_C   = 8'(RECOVER_TIME);
   localparam logic [7:0] WALK_C      = 8'(WALK_TIME);
   localparam logic [7:0] BUZZER_C    = 8'(BUZZER_TIME);

   state_e     state_q, state_d;
   logic [7:0] timer_q, timer_d, total_q, total_d, tot_inc;
   logic       emg_dir_q, emg_dir_d, ped_dir_q, ped_dir_d;
   logic       rr_emg_q, rr_emg_d, rr_ped_q, rr_ped_d;
   logic [1:0] pend_q, pend_d;
   logic       fault_q, fault_d;
   logic       hold_q, buzzer_q;
   logic [1:0] pg_q, wg_q;

   logic emg_gnt, emg_vld, ped_gnt, ped_vld, expire;
   logic enter_clear, enter_preempt, enter_recover, enter_walk, enter_idle;

   rr_arbiter2 u_emg_arb (
      .req_i(bus.emg_req), .last_i(rr_emg_q),
      .gnt_idx_o(emg_gnt), .gnt_vld_o(emg_vld)
   );

   // Uses the latched requests: a press becomes servable one cycle later.
   rr_arbiter2 u_ped_arb (
      .req_i(pend_q), .last_i(rr_ped_q),
      .gnt_idx_o(ped_gnt), .gnt_vld_o(ped_vld)
   );

   assign tot_inc = total_q + 8'd1;
   assign expire  = bus.tick && (timer_q == 8'd1);

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      total_d       = total_q;
      emg_dir_d     = emg_dir_q;
      ped_dir_d     = ped_dir_q;
      rr_emg_d      = rr_emg_q;
      rr_ped_d      = rr_ped_q;
      fault_d       = fault_q;
      enter_clear   = 1'b0;
      enter_preempt = 1'b0;
      enter_recover = 1'b0;
      enter_walk    = 1'b0;
      enter_idle    = 1'b0;
      // A press for the crossing currently walking is dropped.
      pend_d = pend_q | (bus.ped_btn &
               ((state_q == ST_WALK) ? ~dir_onehot(ped_dir_q) : 2'b11));

      case (state_q)
         ST_IDLE: begin
            if (emg_vld)                       enter_clear = 1'b1;
            else if (ped_vld && bus.ctrl_safe) enter_walk  = 1'b1;
         end
         ST_CLEAR: begin
            if (bus.ctrl_safe) enter_preempt = 1'b1;
            else if (expire) begin
               enter_preempt = 1'b1;
               fault_d       = 1'b1;
            end
         end
         ST_PREEMPT: begin
            if (bus.tick) begin
               total_d = tot_inc;
               if (tot_inc >= EMG_MAX_C) enter_recover = 1'b1;
               // Past minimum dwell the timer parks at 1 while requested.
               else if (timer_q == 8'd1) enter_recover = ~bus.emg_req[emg_dir_q];
            end
         end
         ST_RECOVER: begin
            if (expire) begin
               if (emg_vld)      enter_clear = 1'b1;
               else if (ped_vld) enter_walk  = 1'b1;
               else              enter_idle  = 1'b1;
            end
         end
         ST_WALK: begin
            if (emg_vld) enter_clear = 1'b1;
            else if (expire) begin
               if (ped_vld) enter_walk = 1'b1;
               else         enter_idle = 1'b1;
            end
         end
         default: enter_idle = 1'b1;
      endcase

      // Non-expiry ticks count down; a state entry reloads below.
      if (bus.tick && timer_q > 8'd1) timer_d = timer_q - 8'd1;

      if (enter_clear) begin
         state_d   = ST_CLEAR;
         emg_dir_d = emg_gnt;
         timer_d   = CLEAR_C;
      end
      if (enter_preempt) begin
         state_d  = ST_PREEMPT;
         rr_emg_d = emg_dir_q;
         timer_d  = EMG_HOLD_C;
         total_d  = 8'd0;
      end
      if (enter_recover) begin
         state_d = ST_RECOVER;
         timer_d = RECOVER_C;
      end
      if (enter_walk) begin
         state_d   = ST_WALK;
         ped_dir_d = ped_gnt;
         rr_ped_d  = ped_gnt;
         pend_d    = pend_d & ~dir_onehot(ped_gnt);
         timer_d   = WALK_C;
      end
      if (enter_idle) begin
         state_d = ST_IDLE;
         timer_d = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         timer_q   <= 8'd0;
         total_q   <= 8'd0;
         emg_dir_q <= 1'b0;
         ped_dir_q <= 1'b0;
         rr_emg_q  <= 1'b1;
         rr_ped_q  <= 1'b1;
         pend_q    <= 2'b00;
         fault_q   <= 1'b0;
         hold_q    <= 1'b0;
         buzzer_q  <= 1'b0;
         pg_q      <= 2'b00;
         wg_q      <= 2'b00;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         total_q   <= total_d;
         emg_dir_q <= emg_dir_d;
         ped_dir_q <= ped_dir_d;
         rr_emg_q  <= rr_emg_d;
         rr_ped_q  <= rr_ped_d;
         pend_q    <= pend_d;
         fault_q   <= fault_d;
         hold_q    <= (state_d != ST_IDLE);
         buzzer_q  <= (state_d == ST_WALK) && (timer_d <= BUZZER_C);
         pg_q      <= (state_d == ST_PREEMPT) ? dir_onehot(emg_dir_d) : 2'b00;
         wg_q      <= (state_d == ST_WALK)    ? dir_onehot(ped_dir_d) : 2'b00;
      end
   end

   assign bus.hold          = hold_q;
   assign bus.preempt_green = pg_q;
   assign bus.walk_grant    = wg_q;
   assign bus.buzzer        = buzzer_q;
   assign bus.ped_pending   = pend_q;
   assign bus.clear_fault   = fault_q;
   assign bus.state_dbg     = state_q;

endmodule
